mem_port_arbiter: RTL and testbench

- Shares the single-port byte-addressed word memory (32-bit, big-endian, masked write on every clock edge) between an instruction-fetch requester (I) and a load/store requester (D).
- Arbitrates between them round-robin and sequences each access through a fixed 3-state FSM.
- Converts byte, half and word load/store requests into memory address, mask and write-data, and extracts and extends the load result.
- Sits between the CPU fetch/LSU stages and the memory instance.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the shared memory.
// The slave view is what the arbiter sees; the master view is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int M = 10
);
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          i_err;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic          d_unsigned;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;

  logic [M+1:0]  mem_address;
  logic [31:0]   mem_mask;
  logic [31:0]   mem_w;
  logic [31:0]   mem_v;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_v,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_address, mem_mask, mem_w
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_v,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_address, mem_mask, mem_w
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one big-endian byte-addressed word memory between
// instruction fetch and load/store, one access per IDLE/ISSUE/RESP sequence.
module mem_port_arbiter #(
  parameter int M = 10
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int AW = M + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_i, last_i_nxt;
  logic            accept, take_d;
  logic            i_err_new, d_err_new;

  logic            sel_d_p1;
  logic            we_p1;
  logic            uns_p1;
  logic            err_p1;
  logic [1:0]      size_p1;
  logic [AW-1:0]   addr_p1;
  logic [31:0]     wdata_p1;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Out of range when upper address bits are set or the access runs past the last byte.
  function automatic logic range_err(input logic [31:0] addr, input logic [2:0] nbytes);
    logic [AW:0] lim;
    lim = (AW+1)'(1) << AW;
    lim = lim - (AW+1)'(nbytes);
    return (|addr[31:AW]) || ({1'b0, addr[AW-1:0]} > lim);
  endfunction

  function automatic logic [31:0] store_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 32'hFF00_0000;
      2'b01:   return 32'hFFFF_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {wdata[7:0], 24'h0};
      2'b01:   return {wdata[15:0], 16'h0};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [31:0] v);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = v[31:24];
    h = v[31:16];
    case (size)
      2'b00: begin
        ext = b;
        return uns ? {24'h0, v[31:24]} : ext;
      end
      2'b01: begin
        ext = h;
        return uns ? {16'h0, v[31:16]} : ext;
      end
      default: return v;
    endcase
  endfunction

  assign accept    = (state == IDLE) && (bus.i_req || bus.d_req);
  // D wins a tie whenever I was the last one served.
  assign take_d    = bus.d_req && (!bus.i_req || last_i);
  assign i_err_new = range_err(bus.i_addr, 3'd4) || (bus.i_addr[1:0] != 2'b00);
  assign d_err_new = (bus.d_size == 2'b11) || range_err(bus.d_addr, size_bytes(bus.d_size));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_i <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_i <= last_i_nxt;
    end
  end

  // Acceptance: request fields are captured once and held through ISSUE/RESP
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_d_p1 <= take_d;
      if (take_d) begin
        addr_p1  <= bus.d_addr[AW-1:0];
        we_p1    <= bus.d_we;
        size_p1  <= bus.d_size;
        uns_p1   <= bus.d_unsigned;
        wdata_p1 <= bus.d_wdata;
        err_p1   <= d_err_new;
      end else begin
        addr_p1  <= bus.i_addr[AW-1:0];
        we_p1    <= 1'b0;
        size_p1  <= 2'b10;
        uns_p1   <= 1'b0;
        wdata_p1 <= 32'h0;
        err_p1   <= i_err_new;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    last_i_nxt      = last_i;
    bus.i_gnt       = 1'b0;
    bus.i_rvalid    = 1'b0;
    bus.i_rdata     = 32'h0;
    bus.i_err       = 1'b0;
    bus.d_gnt       = 1'b0;
    bus.d_rvalid    = 1'b0;
    bus.d_rdata     = 32'h0;
    bus.d_err       = 1'b0;
    bus.mem_address = '0;
    bus.mem_mask    = 32'h0;
    bus.mem_w       = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = ISSUE;
          last_i_nxt = !take_d;
        end
      end
      ISSUE: begin
        state_nxt       = RESP;
        bus.i_gnt       = !sel_d_p1;
        bus.d_gnt       = sel_d_p1;
        bus.mem_address = addr_p1;
        // The memory writes on every edge, so only a clean store may raise the mask.
        if (sel_d_p1 && we_p1 && !err_p1) begin
          bus.mem_mask = store_mask(size_p1);
          bus.mem_w    = store_data(size_p1, wdata_p1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (sel_d_p1) begin
          bus.d_rvalid = 1'b1;
          bus.d_err    = err_p1;
          if (!we_p1 && !err_p1) bus.d_rdata = load_extract(size_p1, uns_p1, bus.mem_v);
        end else begin
          bus.i_rvalid = 1'b1;
          bus.i_err    = err_p1;
          if (!err_p1) bus.i_rdata = bus.mem_v;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a byte-array reference memory.
module tb_mem_port_arbiter;

  localparam int M     = 10;
  localparam int BYTES = 4 << M;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem     [0:BYTES-1] = '{default: 8'h00};
  logic [7:0] ref_mem [0:BYTES-1] = '{default: 8'h00};

  mem_port_arbiter_if #(.M(M)) bus ();

  mem_port_arbiter #(.M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory instance: reads bytes addr..addr+3 big-endian, masked write on every edge.
  always @(posedge clk) begin
    int a;
    a = int'(bus.mem_address);
    bus.mem_v <= {mem[a % BYTES], mem[(a + 1) % BYTES], mem[(a + 2) % BYTES], mem[(a + 3) % BYTES]};
    for (int k = 0; k < 4; k++)
      if (bus.mem_mask[31-8*k -: 8] == 8'hFF) mem[(a + k) % BYTES] <= bus.mem_w[31-8*k -: 8];
  end

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = int'((addr + 32'(k)) % 32'(BYTES));
      v = (v << 8) | {24'h0, ref_mem[idx]};
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
  endtask

  // One D transaction starting at an IDLE-cycle negedge; returns the observed d_rdata.
  task automatic do_d(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input string name, output logic [31:0] got);
    int n;
    logic e;
    logic [31:0] exp_rd, exp_mask, exp_w;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e = (size == 2'b11) || (64'(addr) + 64'(n) > 64'(BYTES));
    exp_rd = 32'h0; exp_mask = 32'h0; exp_w = 32'h0;
    if (!e && !we) begin
      exp_rd = ref_read(addr, n);
      if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
    end
    if (!e && we) begin
      exp_mask = 32'hFFFF_FFFF << (32 - 8*n);
      exp_w    = wdata << (32 - 8*n);
    end
    bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_unsigned = uns;
    bus.d_addr = addr; bus.d_wdata = wdata;
    @(negedge clk);
    checks += 3;
    if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL %s gnt: d_gnt=%b i_gnt=%b d_rvalid=%b want 1 0 0", name, bus.d_gnt, bus.i_gnt, bus.d_rvalid);
    end
    if (bus.mem_mask !== exp_mask) begin
      errors++; $display("FAIL %s mask: got %h want %h", name, bus.mem_mask, exp_mask);
    end
    if (bus.mem_address !== 12'(addr)) begin
      errors++; $display("FAIL %s address: got %h want %h", name, bus.mem_address, 12'(addr));
    end
    if (!e) begin
      checks++;
      if (bus.mem_w !== exp_w) begin
        errors++; $display("FAIL %s wdata: got %h want %h", name, bus.mem_w, exp_w);
      end
    end
    // Fields change after acceptance; the access must use the latched values.
    bus.d_req = 1'b0; bus.d_addr = $urandom; bus.d_wdata = $urandom;
    bus.d_size = 2'($urandom); bus.d_we = 1'($urandom); bus.d_unsigned = 1'($urandom);
    if (!e && we)
      for (int k = 0; k < n; k++)
        ref_mem[int'((addr + 32'(k)) % 32'(BYTES))] = 8'(wdata >> (8*(n-1-k)));
    @(negedge clk);
    got = bus.d_rdata;
    checks += 4;
    if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b0) begin
      errors++; $display("FAIL %s rvalid: d=%b i=%b want 1 0", name, bus.d_rvalid, bus.i_rvalid);
    end
    if (bus.d_err !== e) begin
      errors++; $display("FAIL %s err: got %b want %b", name, bus.d_err, e);
    end
    if (bus.d_rdata !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, bus.d_rdata, exp_rd);
    end
    if (bus.mem_mask !== 32'h0 || bus.d_gnt !== 1'b0) begin
      errors++; $display("FAIL %s resp: mask=%h d_gnt=%b want 0 0", name, bus.mem_mask, bus.d_gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.d_gnt !== 1'b0) begin
      errors++; $display("FAIL %s idle: d_rvalid=%b d_gnt=%b want 0 0", name, bus.d_rvalid, bus.d_gnt);
    end
  endtask

  task automatic do_i(input logic [31:0] addr, input string name, output logic [31:0] got);
    logic e;
    logic [31:0] exp_rd;
    e = (addr[1:0] != 2'b00) || (64'(addr) + 64'd4 > 64'(BYTES));
    exp_rd = e ? 32'h0 : ref_read(addr, 4);
    bus.i_req = 1'b1; bus.i_addr = addr;
    @(negedge clk);
    checks += 2;
    if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      errors++; $display("FAIL %s gnt: i_gnt=%b d_gnt=%b want 1 0", name, bus.i_gnt, bus.d_gnt);
    end
    if (bus.mem_mask !== 32'h0) begin
      errors++; $display("FAIL %s mask: got %h want 0", name, bus.mem_mask);
    end
    bus.i_req = 1'b0; bus.i_addr = $urandom;
    @(negedge clk);
    got = bus.i_rdata;
    checks += 3;
    if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL %s rvalid: i=%b d=%b want 1 0", name, bus.i_rvalid, bus.d_rvalid);
    end
    if (bus.i_err !== e) begin
      errors++; $display("FAIL %s err: got %b want %b", name, bus.i_err, e);
    end
    if (bus.i_rdata !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, bus.i_rdata, exp_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if ({bus.i_gnt, bus.i_rvalid, bus.i_err, bus.d_gnt, bus.d_rvalid, bus.d_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {bus.i_gnt, bus.i_rvalid, bus.i_err, bus.d_gnt, bus.d_rvalid, bus.d_err});
    end
    if (bus.mem_mask !== 32'h0 || bus.mem_w !== 32'h0 || bus.mem_address !== 12'h0) begin
      errors++; $display("FAIL reset_mem: mask=%h w=%h addr=%h want 0", bus.mem_mask, bus.mem_w, bus.mem_address);
    end
    if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: i=%h d=%h want 0", bus.i_rdata, bus.d_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [31:0] exp_rd;
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_unsigned = 1'b0;
    bus.d_addr = 32'h10; bus.d_wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = ref_read(32'h10, 4);
    for (int k = 1; k <= 12; k++) begin
      int  phase;
      logic win_d;
      @(negedge clk);
      phase = (k - 1) % 3;
      win_d = (((k - 1) / 3) % 2) == 0;
      checks += 3;
      if (bus.d_gnt !== (phase == 0 && win_d) || bus.i_gnt !== (phase == 0 && !win_d)) begin
        errors++; $display("FAIL contention_gnt cycle %0d: d_gnt=%b i_gnt=%b", k, bus.d_gnt, bus.i_gnt);
      end
      if (bus.d_rvalid !== (phase == 1 && win_d) || bus.i_rvalid !== (phase == 1 && !win_d)) begin
        errors++; $display("FAIL contention_rvalid cycle %0d: d=%b i=%b", k, bus.d_rvalid, bus.i_rvalid);
      end
      if (bus.mem_mask !== 32'h0) begin
        errors++; $display("FAIL contention_mask cycle %0d: got %h want 0", k, bus.mem_mask);
      end
      if (phase == 1) begin
        checks++;
        if ((win_d ? bus.d_rdata : bus.i_rdata) !== exp_rd) begin
          errors++; $display("FAIL contention_rdata cycle %0d: got %h want %h", k, win_d ? bus.d_rdata : bus.i_rdata, exp_rd);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_store_fetch();
    logic [31:0] got;
    do_d(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, "store_word", got);
    do_i(32'h10, "fetch_word", got);
    checks++;
    if (got !== 32'h1122_3344) begin
      errors++; $display("FAIL fetch_const: got %h want 11223344", got);
    end
  endtask

  task automatic test_subword();
    logic [31:0] got;
    do_d(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "load_byte", got);
    checks++;
    if (got !== 32'h0000_0022) begin
      errors++; $display("FAIL byte_const: got %h want 00000022", got);
    end
    do_d(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, "store_half", got);
    do_d(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "load_word", got);
    checks++;
    if (got !== 32'h1122_BEEF) begin
      errors++; $display("FAIL half_const: got %h want 1122beef", got);
    end
  endtask

  task automatic test_extension();
    logic [31:0] got;
    do_d(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080, "store_byte", got);
    do_d(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, "load_sbyte", got);
    checks++;
    if (got !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL sbyte_const: got %h want ffffff80", got);
    end
    do_d(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, "load_ubyte", got);
    checks++;
    if (got !== 32'h0000_0080) begin
      errors++; $display("FAIL ubyte_const: got %h want 00000080", got);
    end
    do_d(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, "load_shalf", got);
    checks++;
    if (got !== 32'hFFFF_8000) begin
      errors++; $display("FAIL shalf_const: got %h want ffff8000", got);
    end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    do_i(32'h6, "fetch_misaligned", got);
    do_i(32'h1000, "fetch_range", got);
    do_d(1'b1, 2'b10, 1'b0, 32'hFFD, 32'hCAFE_F00D, "store_past_end", got);
    do_d(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, "size_reserved", got);
    do_d(1'b1, 2'b11, 1'b0, 32'h30, 32'h1234_5678, "store_reserved", got);
    do_d(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, "load_range", got);
    do_d(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hA1B2_C3D4, "store_last_word", got);
    do_d(1'b1, 2'b00, 1'b0, 32'hFFF, 32'h0000_005A, "store_last_byte", got);
    do_d(1'b0, 2'b01, 1'b1, 32'hFFE, 32'h0, "load_last_half", got);
    do_d(1'b0, 2'b01, 1'b1, 32'hFFF, 32'h0, "half_past_end", got);
  endtask

  task automatic test_random();
    logic [31:0] got, addr;
    logic [1:0]  size;
    for (int t = 0; t < 60; t++) begin
      int p;
      p = $urandom_range(0, 9);
      addr = (p == 0) ? 32'hFF8 + 32'($urandom_range(0, 7)) :
             (p == 1) ? $urandom : 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        do_i(addr, "rand_fetch", got);
      end else begin
        size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        do_d(1'($urandom), size, 1'($urandom), addr, $urandom, "rand_data", got);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [31:0] got;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_unsigned = 1'b0;
    bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_mask !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL abort_issue: d_gnt=%b mask=%h want 1 ffffffff", bus.d_gnt, bus.mem_mask);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_mask !== 32'h0 || bus.d_gnt !== 1'b0 || bus.mem_w !== 32'h0 || bus.mem_address !== 12'h0) begin
      errors++; $display("FAIL abort_outputs: mask=%h gnt=%b w=%h addr=%h want 0", bus.mem_mask, bus.d_gnt, bus.mem_w, bus.mem_address);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.d_rvalid !== 1'b0 || bus.i_rvalid !== 1'b0) begin
        errors++; $display("FAIL abort_rvalid cycle %0d: d=%b i=%b want 0 0", k, bus.d_rvalid, bus.i_rvalid);
      end
    end
    do_d(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "load_after_abort", got);
    checks++;
    if (got !== 32'h0) begin
      errors++; $display("FAIL abort_const: got %h want 00000000", got);
    end
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int i = 0; i < BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL memory_image: %0d bytes differ, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_store_fetch();
    test_subword();
    test_extension();
    test_errors();
    test_random();
    test_reset_mid_issue();
    test_memory_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
